master_i2c: RTL and testbench

I2C single-byte initiator: the controller-side counterpart of the I2C responder, driving SCL and SDA open-drain to write one byte to, or read one byte from, a 7-bit-addressed device. Sits between local control logic (command/response handshake) and the shared two-wire bus. Generates START, address+R/W, data, ACK/NACK, and STOP with fixed quarter-bit timing derived from the system clock.

---
 rtl/master_i2c.sv | 259 +++++++++++++++++++++++++
 tb/tb_master_i2c.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/master_i2c.sv
// master_i2c: single-byte I2C initiator.
// Writes one byte to, or reads one byte from, a 7-bit-addressed device over
// an open-drain SCL/SDA pair. Each bit slot is four quarters of CLK_DIV
// system clocks; SCL is low in quarters 0-1 and released in quarters 2-3.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-low reset
//   start     one-cycle command strobe (accepted only in IDLE, not on done)
//   rw        0 = write wdata, 1 = read into rdata (captured with start)
//   dev_addr  7-bit target address (captured with start)
//   wdata     byte to write (captured with start)
//   busy      high from the cycle after an accepted start until done
//   done      one-cycle pulse at the end of a transaction
//   ack_err   address or write-data NACK seen; valid with done
//   rdata     read byte, updated at done of a successful read
//   scl, sda  open-drain bus lines: driven 0 or released to Z
//
// Optional build macro: I2C_MASTER_CLKSTRETCH_EN enables responder clock
// stretching (the quarter counter holds in P2 while SCL reads low).
module master_i2c #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  inout  wire        scl,
  inout  wire        sda
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    START  = 4'd1,
    ADDR   = 4'd2,
    ACK_A  = 4'd3,
    WDATA  = 4'd4,
    ACK_W  = 4'd5,
    RDATA  = 4'd6,
    NACK_R = 4'd7,
    STOP   = 4'd8
  } state_t;

  state_t          state_r, state_s;
  logic [1:0]      phase_r, phase_s;
  logic [QW-1:0]   qcnt_r, qcnt_s;
  logic [3:0]      bit_r, bit_s;
  logic [6:0]      addr_r;
  logic            rw_r;
  logic [7:0]      wdata_r;
  logic [7:0]      rx_r, rx_s;
  logic            ack_err_r, ack_err_s;
  logic [7:0]      rdata_r, rdata_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;
  logic            scl_low_r, sda_low_r;
  logic            sda_sync_r;
  logic            accept_s, qend_s, slot_end_s, sample_s, hold_s;
  logic [7:0]      tx_byte_s;
  logic            tx_bit_s;
`ifdef I2C_MASTER_CLKSTRETCH_EN
  logic            scl_sync_r;
`endif

  // Bus drive for a given slot position: returns {scl_low, sda_low}.
  function automatic logic [1:0] drive_f(input state_t st, input logic [1:0] ph,
                                         input logic txb);
    logic [1:0] d;
    case (st)
      IDLE:                       d = 2'b00;
      START:                      d = {1'b0, ph[1]};
      ADDR, WDATA:                d = {~ph[1], ~txb};
      ACK_A, ACK_W, RDATA, NACK_R: d = {~ph[1], 1'b0};
      // Q0,Q1 both low; Q2 SCL released, SDA low; Q3 both released
      STOP:                       d = {~ph[1], ~(ph == 2'd3)};
      default:                    d = 2'b00;
    endcase
    return d;
  endfunction

  assign scl     = scl_low_r ? 1'b0 : 1'bz;
  assign sda     = sda_low_r ? 1'b0 : 1'bz;
  assign busy    = busy_r;
  assign done    = done_r;
  assign ack_err = ack_err_r;
  assign rdata   = rdata_r;

  // Next-state, slot timing, sampling and result logic.
  always_comb begin
    state_s    = state_r;
    phase_s    = phase_r;
    qcnt_s     = qcnt_r;
    bit_s      = bit_r;
    rx_s       = rx_r;
    ack_err_s  = ack_err_r;
    rdata_s    = rdata_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    // A start arriving in the done cycle is dropped on purpose.
    accept_s   = (state_r == IDLE) && !done_r && start;
    qend_s     = (qcnt_r == QMAX);
    slot_end_s = qend_s && (phase_r == 2'd3);
    sample_s   = (phase_r == 2'd3) && (qcnt_r == '0);
`ifdef I2C_MASTER_CLKSTRETCH_EN
    // The SCL sample lags the pin by one cycle, so the second P2 cycle sees
    // the pin as it was in the first P2 cycle.
    hold_s     = (state_r != IDLE) && (state_r != START) && (phase_r == 2'd2) &&
                 (qcnt_r == QW'(1)) && !scl_sync_r;
`else
    hold_s     = 1'b0;
`endif

    if (state_r == IDLE) begin
      phase_s = 2'd0;
      qcnt_s  = '0;
    end else if (hold_s) begin
      qcnt_s = qcnt_r;
    end else if (qend_s) begin
      qcnt_s  = '0;
      phase_s = phase_r + 2'd1;
    end else begin
      qcnt_s = qcnt_r + QW'(1);
    end

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s   = START;
          busy_s    = 1'b1;
          ack_err_s = 1'b0;
          bit_s     = 4'd0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (slot_end_s) begin
          state_s = ADDR;
          bit_s   = 4'd0;
        end else begin
          state_s = START;
        end
      end
      ADDR, WDATA, RDATA: begin
        if (sample_s && (state_r == RDATA)) begin
          rx_s = {rx_r[6:0], sda_sync_r};
        end else begin
          rx_s = rx_r;
        end
        if (slot_end_s && (bit_r == 4'd7)) begin
          bit_s = 4'd0;
          case (state_r)
            ADDR:    state_s = ACK_A;
            WDATA:   state_s = ACK_W;
            default: state_s = NACK_R;
          endcase
        end else if (slot_end_s) begin
          bit_s = bit_r + 4'd1;
        end else begin
          bit_s = bit_r;
        end
      end
      ACK_A, ACK_W: begin
        if (sample_s && sda_sync_r) begin
          ack_err_s = 1'b1;
        end else begin
          ack_err_s = ack_err_r;
        end
        // ack_err_r already holds this slot's sample by the slot end
        if (slot_end_s && (state_r == ACK_A) && !ack_err_r) begin
          state_s = rw_r ? RDATA : WDATA;
        end else if (slot_end_s) begin
          state_s = STOP;
        end else begin
          state_s = state_r;
        end
      end
      NACK_R: begin
        if (slot_end_s) begin
          state_s = STOP;
        end else begin
          state_s = NACK_R;
        end
      end
      STOP: begin
        if (slot_end_s) begin
          state_s = IDLE;
          done_s  = 1'b1;
          busy_s  = 1'b0;
          rdata_s = (rw_r && !ack_err_r) ? rx_r : rdata_r;
        end else begin
          state_s = STOP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Bit to present on SDA for the slot being entered.
  always_comb begin
    tx_byte_s = (state_s == ADDR) ? {addr_r, rw_r} : wdata_r;
    tx_bit_s  = tx_byte_s[3'd7 - bit_s[2:0]];
  end

  // State, counters, command capture, registered bus drive and pin samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      phase_r    <= 2'd0;
      qcnt_r     <= '0;
      bit_r      <= 4'd0;
      addr_r     <= 7'd0;
      rw_r       <= 1'b0;
      wdata_r    <= 8'd0;
      rx_r       <= 8'd0;
      ack_err_r  <= 1'b0;
      rdata_r    <= 8'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      scl_low_r  <= 1'b0;
      sda_low_r  <= 1'b0;
      sda_sync_r <= 1'b1;
`ifdef I2C_MASTER_CLKSTRETCH_EN
      scl_sync_r <= 1'b1;
`endif
    end else begin
      state_r    <= state_s;
      phase_r    <= phase_s;
      qcnt_r     <= qcnt_s;
      bit_r      <= bit_s;
      rx_r       <= rx_s;
      ack_err_r  <= ack_err_s;
      rdata_r    <= rdata_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      if (accept_s) begin
        addr_r  <= dev_addr;
        rw_r    <= rw;
        wdata_r <= wdata;
      end
      // Driven from next-state so the lines change on the first cycle of a quarter
      {scl_low_r, sda_low_r} <= drive_f(state_s, phase_s, tx_bit_s);
      sda_sync_r <= sda;
`ifdef I2C_MASTER_CLKSTRETCH_EN
      scl_sync_r <= scl;
`endif
    end
  end

endmodule

// File: tb/tb_master_i2c.sv
// Testbench for master_i2c: table-driven transactions against a cycle-sampled
// I2C responder model, plus hand-written reset, busy-start and done-cycle
// sequences.
module tb_master_i2c;

  localparam int CD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev_addr = 7'd0;
  logic [7:0] wdata = 8'd0;
  logic       busy, done, ack_err;
  logic [7:0] rdata;
  wire        scl, sda;

  logic tb_scl_low = 1'b0;
  logic tb_sda_low = 1'b0;
  assign scl = tb_scl_low ? 1'b0 : 1'bz;
  assign sda = tb_sda_low ? 1'b0 : 1'bz;
  pullup (scl);
  pullup (sda);

  master_i2c #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .dev_addr(dev_addr),
    .wdata(wdata), .busy(busy), .done(done), .ack_err(ack_err),
    .rdata(rdata), .scl(scl), .sda(sda)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // responder configuration (set by the stimulus process)
  logic       resp_en = 1'b0;
  logic [6:0] resp_addr = 7'd0;
  logic       resp_data_ack = 1'b0;
  logic [7:0] resp_rdval = 8'd0;
  logic       stretch_en = 1'b0;

  // responder observations (written only by the responder process)
  logic [7:0] cap0 = 8'd0;
  logic [7:0] cap1 = 8'd0;
  logic       ack8_1 = 1'b0;
  int         start_cnt = 0;
  int         start_cyc = 0;

  // Responder model: samples the bus each falling clk edge.
  initial begin : responder
    logic p_scl, p_sda, s_scl, s_sda, acked;
    logic [7:0] sh;
    logic [2:0] idx;
    int bitn, byte_idx, stretch_cnt;
    p_scl = 1'b1; p_sda = 1'b1; acked = 1'b0; sh = 8'd0;
    bitn = 0; byte_idx = 3; stretch_cnt = 0;
    forever begin
      @(negedge clk);
      s_scl = scl;
      s_sda = sda;
      if (p_scl && s_scl && p_sda && !s_sda) begin
        start_cnt = start_cnt + 1;
        start_cyc = cyc;
        bitn = 0; byte_idx = 0; acked = 1'b0; tb_sda_low = 1'b0;
      end else if (p_scl && s_scl && !p_sda && s_sda) begin
        byte_idx = 3; tb_sda_low = 1'b0;
      end else if (!p_scl && s_scl) begin
        if (bitn == 8) begin
          if (byte_idx == 1) ack8_1 = s_sda;
          bitn = 0;
          byte_idx = byte_idx + 1;
        end else begin
          sh = {sh[6:0], s_sda};
          bitn = bitn + 1;
          if (bitn == 8 && byte_idx == 0) cap0 = sh;
          if (bitn == 8 && byte_idx == 1) cap1 = sh;
        end
      end else if (p_scl && !s_scl) begin
        if (byte_idx == 0 && bitn == 8) begin
          acked = resp_en && (cap0[7:1] == resp_addr);
          tb_sda_low = acked;
          if (stretch_en) stretch_cnt = 2 * CD + 20;
        end else if (byte_idx == 1 && acked && cap0[0] && bitn < 8) begin
          idx = 3'(7 - bitn);
          tb_sda_low = !resp_rdval[idx];
        end else if (byte_idx == 1 && acked && !cap0[0] && bitn == 8) begin
          tb_sda_low = resp_data_ack;
        end else begin
          tb_sda_low = 1'b0;
        end
      end
      if (stretch_cnt > 0) begin
        tb_scl_low = 1'b1;
        stretch_cnt = stretch_cnt - 1;
      end else begin
        tb_scl_low = 1'b0;
      end
      p_scl = s_scl;
      p_sda = s_sda;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wd;
    logic       ren;
    logic [6:0] raddr;
    logic       rdack;
    logic [7:0] rval;
    logic       e_err;
    logic [7:0] e_rdata;
    logic [7:0] e_abyte;
    logic       chk_d;
    logic [7:0] e_dbyte;
    int         e_lat;
  } vec_t;

  vec_t vt[7];

  // glitch: cycle offset for a start pulse while busy (-1 = none)
  // at_done: pulse start in the done cycle and expect it ignored
  task automatic run_vec(input vec_t v, input string nm, input int glitch, input bit at_done);
    int tb, n, s0;
    resp_en = v.ren; resp_addr = v.raddr; resp_data_ack = v.rdack; resp_rdval = v.rval;
    s0 = start_cnt;
    @(negedge clk);
    start = 1'b1; rw = v.rw; dev_addr = v.addr; wdata = v.wd;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy_rise"}, 32'(busy), 32'd1);
    tb = cyc;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n = n + 1;
      if (n == glitch) begin
        start = 1'b1; dev_addr = 7'h22; rw = 1'b1; wdata = 8'hFF;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, 32'(done), 32'd1);
    chk({nm, "_latency"}, 32'(cyc - tb), 32'(v.e_lat));
    chk({nm, "_sda_start_fall"}, 32'(start_cyc - tb), 32'(2 * CD));
    chk({nm, "_start_count"}, 32'(start_cnt - s0), 32'd1);
    chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({nm, "_ack_err"}, 32'(ack_err), 32'(v.e_err));
    chk({nm, "_rdata"}, 32'(rdata), 32'(v.e_rdata));
    chk({nm, "_addr_byte"}, 32'(cap0), 32'(v.e_abyte));
    if (v.chk_d) chk({nm, "_data_byte"}, 32'(cap1), 32'(v.e_dbyte));
    if (v.chk_d && v.rw) chk({nm, "_master_nack"}, 32'(ack8_1), 32'd1);
    if (at_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_done_pulse_end"}, 32'(done), 32'd0);
    if (at_done) begin
      chk({nm, "_start_at_done_ignored"}, 32'(busy), 32'd0);
      @(negedge clk);
      chk({nm, "_still_idle"}, 32'(busy), 32'd0);
    end
    chk({nm, "_bus_released"}, 32'({scl, sda}), 32'h3);
    repeat (10) @(negedge clk);
  endtask

  initial begin : stim
    int seen;
    vec_t v;
    //        rw    addr   wd     ren   raddr  rdack rval   err   rdata  abyte  chk_d dbyte  lat
    vt[0] = '{1'b0, 7'h50, 8'hA5, 1'b1, 7'h50, 1'b1, 8'h00, 1'b0, 8'h00, 8'hA0, 1'b1, 8'hA5, 320};
    vt[1] = '{1'b1, 7'h50, 8'h00, 1'b1, 7'h50, 1'b1, 8'h3C, 1'b0, 8'h3C, 8'hA1, 1'b1, 8'h3C, 320};
    vt[2] = '{1'b0, 7'h50, 8'hA5, 1'b0, 7'h50, 1'b1, 8'h00, 1'b1, 8'h3C, 8'hA0, 1'b0, 8'h00, 176};
    vt[3] = '{1'b0, 7'h2A, 8'h00, 1'b1, 7'h2A, 1'b1, 8'h00, 1'b0, 8'h3C, 8'h54, 1'b1, 8'h00, 320};
    vt[4] = '{1'b1, 7'h7F, 8'h00, 1'b1, 7'h7F, 1'b1, 8'hC3, 1'b0, 8'hC3, 8'hFF, 1'b1, 8'hC3, 320};
    vt[5] = '{1'b1, 7'h50, 8'h00, 1'b1, 7'h51, 1'b1, 8'h99, 1'b1, 8'hC3, 8'hA1, 1'b0, 8'h00, 176};
    vt[6] = '{1'b0, 7'h11, 8'h5A, 1'b1, 7'h11, 1'b0, 8'h00, 1'b1, 8'hC3, 8'h22, 1'b1, 8'h5A, 320};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_ack_err", 32'(ack_err), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'h00);
    chk("reset_bus", 32'({scl, sda}), 32'h3);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_vec(vt[i], $sformatf("vec%0d", i), -1, 1'b0);
    end

    // start pulsed mid-transfer with a different address must be ignored
    v = vt[4];
    v.e_rdata = 8'hC3;
    run_vec(v, "busy_start", 40, 1'b1);

    // synchronous reset during WDATA bit 3 abandons the transfer
    resp_en = 1'b1; resp_addr = 7'h50; resp_data_ack = 1'b1;
    @(negedge clk);
    start = 1'b1; rw = 1'b0; dev_addr = 7'h50; wdata = 8'hA5;
    @(negedge clk);
    start = 1'b0;
    chk("midrst_busy_rise", 32'(busy), 32'd1);
    repeat (210) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_bus", 32'({scl, sda}), 32'h3);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    rst = 1'b1;
    seen = 0;
    repeat (400) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    v = vt[0];
    run_vec(v, "after_rst", -1, 1'b0);

`ifdef I2C_MASTER_CLKSTRETCH_EN
    stretch_en = 1'b1;
    v = vt[0];
    v.e_lat = 340;
    run_vec(v, "stretch", -1, 1'b0);
    stretch_en = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
